// File: rtl/uart_rx_core.sv
// 8N1 UART receiver with a one-entry ready/valid holding buffer, sticky overrun and pulsed framing error.
// Define UART_RX_PARITY_EN for 8E1 frames with a pulsed parity_err output.
module uart_rx_core #(
  parameter int CLOCK_FREQ = 100_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       serial_in,
  output logic [7:0] data_out,
  output logic       data_out_valid,
  input  logic       data_out_ready,
  output logic       frame_err,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic       overrun,
  input  logic       overrun_clear
);

  localparam int SYMBOL_EDGE = CLOCK_FREQ / BAUD_RATE;
  localparam int SAMPLE_TIME = SYMBOL_EDGE / 2;
  localparam int CNT_W       = $clog2(SYMBOL_EDGE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [1:0]       r_sync;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]       r_idx, w_idx_nxt;
  logic [7:0]       r_shift, w_shift_nxt;
  logic             r_done, w_done_nxt;
  logic             r_ferr, w_ferr_nxt;
  logic [7:0]       r_data;
  logic             r_valid;
  logic             r_ovr;
  logic             w_rx;
  logic             w_ovr_set;
  logic             w_sym_end;
`ifdef UART_RX_PARITY_EN
  logic             r_pbad, w_pbad_nxt;
  logic             r_perr, w_perr_nxt;
`endif

  assign w_rx      = r_sync[1];
  assign w_sym_end = (r_cnt == CNT_W'(SYMBOL_EDGE - 1));
  assign w_ovr_set = r_done & r_valid & ~data_out_ready;

  // Line synchronizer and receive FSM state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync  <= 2'b11;
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= 3'd0;
      r_shift <= 8'd0;
      r_done  <= 1'b0;
      r_ferr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_pbad  <= 1'b0;
      r_perr  <= 1'b0;
`endif
    end else begin
      r_sync  <= {r_sync[0], serial_in};
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
      r_done  <= w_done_nxt;
      r_ferr  <= w_ferr_nxt;
`ifdef UART_RX_PARITY_EN
      r_pbad  <= w_pbad_nxt;
      r_perr  <= w_perr_nxt;
`endif
    end
  end

  // Next-state, bit sampling and completion/error strobes
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CNT_W'(1);
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_done_nxt  = 1'b0;
    w_ferr_nxt  = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_pbad_nxt  = r_pbad;
    w_perr_nxt  = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (!w_rx) begin
          w_state_nxt = S_START;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_START: begin
        if (r_cnt == CNT_W'(SAMPLE_TIME - 1)) begin
          w_cnt_nxt = '0;
          w_idx_nxt = 3'd0;
          if (!w_rx) begin
            w_state_nxt = S_DATA;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_state_nxt = S_START;
        end
      end
      S_DATA: begin
        if (w_sym_end) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = {w_rx, r_shift[7:1]};
          w_idx_nxt   = r_idx + 3'd1;
          if (r_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            w_state_nxt = S_PARITY;
`else
            w_state_nxt = S_STOP;
`endif
          end else begin
            w_state_nxt = S_DATA;
          end
        end else begin
          w_state_nxt = S_DATA;
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (w_sym_end) begin
          w_cnt_nxt   = '0;
          w_pbad_nxt  = ^{r_shift, w_rx};
          w_perr_nxt  = ^{r_shift, w_rx};
          w_state_nxt = S_STOP;
        end else begin
          w_state_nxt = S_PARITY;
        end
      end
`endif
      S_STOP: begin
        if (w_sym_end) begin
          w_cnt_nxt = '0;
          if (w_rx) begin
`ifdef UART_RX_PARITY_EN
            w_done_nxt = ~r_pbad;
`else
            w_done_nxt = 1'b1;
`endif
            w_state_nxt = S_IDLE;
          end else begin
            w_ferr_nxt  = 1'b1;
            w_state_nxt = S_WAIT_HIGH;
          end
        end else begin
          w_state_nxt = S_STOP;
        end
      end
      S_WAIT_HIGH: begin
        w_cnt_nxt = '0;
        if (w_rx) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_WAIT_HIGH;
        end
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Holding buffer: a completing byte is accepted if the slot is free or being drained this cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data  <= 8'd0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      if (r_done && (!r_valid || data_out_ready)) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
      end else if (r_valid && data_out_ready) begin
        r_valid <= 1'b0;
      end else begin
        r_valid <= r_valid;
      end
      if (w_ovr_set) begin
        r_ovr <= 1'b1;
      end else if (overrun_clear) begin
        r_ovr <= 1'b0;
      end else begin
        r_ovr <= r_ovr;
      end
    end
  end

  assign data_out       = r_data;
  assign data_out_valid = r_valid;
  assign frame_err      = r_ferr;
  assign overrun        = r_ovr;
`ifdef UART_RX_PARITY_EN
  assign parity_err     = r_perr;
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: directed scenarios plus randomized frames scored
// against a frame-level model of the holding buffer and overrun flag.
module tb_uart_rx_core;

  localparam int CYC_PER_BIT = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       serial_in = 1'b1;
  logic [7:0] data_out;
  logic       data_out_valid;
  logic       ready = 1'b0;
  logic       frame_err;
  logic       overrun;
  logic       overrun_clear = 1'b0;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
  int         perr_cnt = 0;
`endif

  int n_chk  = 0;
  int n_pass = 0;
  int ferr_cnt = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  logic       m_full = 1'b0;
  logic [7:0] m_data = 8'd0;
  logic       m_ovr  = 1'b0;

  uart_rx_core #(.CLOCK_FREQ(1_000_000), .BAUD_RATE(100_000)) dut (
    .clk            (clk),
    .rst            (rst),
    .serial_in      (serial_in),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .data_out_ready (ready),
    .frame_err      (frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err     (parity_err),
`endif
    .overrun        (overrun),
    .overrun_clear  (overrun_clear)
  );

  always #5 clk = ~clk;

  // Observe accepted bytes and error pulses between clock edges
  always @(negedge clk) begin
    if (rst && data_out_valid && ready) got_q.push_back(data_out);
    if (frame_err) ferr_cnt++;
`ifdef UART_RX_PARITY_EN
    if (parity_err) perr_cnt++;
`endif
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic v);
    serial_in = v;
    repeat (CYC_PER_BIT) tick();
  endtask

  // Frame-level model: a good byte goes straight to the consumer, fills the slot, or overruns
  task automatic model_byte(input logic [7:0] b);
    if (ready) exp_q.push_back(b);
    else if (!m_full) begin
      m_full = 1'b1;
      m_data = b;
    end else m_ovr = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(^b);
`endif
    drive_bit(stop_bit);
    serial_in = 1'b1;
    if (stop_bit) model_byte(b);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_bad_parity(input logic [7:0] b);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(~(^b));
    drive_bit(1'b1);
  endtask
`endif

  task automatic consume();
    ready = 1'b1;
    if (m_full) exp_q.push_back(m_data);
    m_full = 1'b0;
    tick();
    ready = 1'b0;
    #3;
    check("valid_after_pop", data_out_valid, 1'b0);
  endtask

  initial begin
    logic [7:0] rb;
    int gap;
    int f0;
    // Reset state
    #12;
    check("rst_data", data_out, 8'h00);
    check("rst_valid", data_out_valid, 1'b0);
    check("rst_ferr", frame_err, 1'b0);
    check("rst_ovr", overrun, 1'b0);
    rst = 1'b1;
    repeat (5) tick();

    // Single byte held until a one-cycle ready pulse
    send_frame(8'hA5, 1'b1);
    repeat (3) tick();
    check("a5_valid", data_out_valid, 1'b1);
    check("a5_data", data_out, 8'hA5);
    repeat (20) tick();
    check("a5_hold", data_out, 8'hA5);
    consume();

    // Back-to-back frames with the consumer always ready
    ready = 1'b1;
    f0 = ferr_cnt;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    repeat (20) tick();
    ready = 1'b0;
    check("b2b_ovr", overrun, m_ovr);
    check("b2b_ferr", ferr_cnt - f0, 0);
    check("b2b_valid", data_out_valid, 1'b0);

    // Overrun with the consumer stalled, clear, then a second overrun
    send_frame(8'h11, 1'b1);
    repeat (3) tick();
    send_frame(8'h22, 1'b1);
    repeat (3) tick();
    check("ovr_data", data_out, m_data);
    check("ovr_set", overrun, m_ovr);
    overrun_clear = 1'b1;
    tick();
    overrun_clear = 1'b0;
    m_ovr = 1'b0;
    check("ovr_clr", overrun, m_ovr);
    send_frame(8'h33, 1'b1);
    repeat (3) tick();
    check("ovr_data2", data_out, 8'h11);
    check("ovr_set2", overrun, m_ovr);
    consume();
    overrun_clear = 1'b1;
    tick();
    overrun_clear = 1'b0;
    m_ovr = 1'b0;

    // Start-bit glitch shorter than half a bit
    f0 = ferr_cnt;
    serial_in = 1'b0;
    repeat (3) tick();
    serial_in = 1'b1;
    repeat (20) tick();
    check("glitch_valid", data_out_valid, 1'b0);
    check("glitch_ferr", ferr_cnt - f0, 0);
    send_frame(8'h5A, 1'b1);
    repeat (3) tick();
    check("post_glitch", data_out, 8'h5A);
    consume();

    // Framing error followed by a held-low break
    f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0);
    serial_in = 1'b0;
    repeat (50) tick();
    serial_in = 1'b1;
    repeat (20) tick();
    check("break_ferr", ferr_cnt - f0, 1);
    check("break_valid", data_out_valid, 1'b0);
    send_frame(8'h3C, 1'b1);
    repeat (3) tick();
    check("post_break", data_out, 8'h3C);
    check("post_break_v", data_out_valid, 1'b1);

    // Reset after bit 3 of a frame, with a byte still buffered
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(i[0]);
    rst = 1'b0;
    m_full = 1'b0;
    m_ovr = 1'b0;
    #1;
    check("mid_rst_data", data_out, 8'h00);
    check("mid_rst_valid", data_out_valid, 1'b0);
    check("mid_rst_ovr", overrun, 1'b0);
    check("mid_rst_ferr", frame_err, 1'b0);
    repeat (3) tick();
    serial_in = 1'b1;
    rst = 1'b1;
    repeat (5) tick();
    send_frame(8'h81, 1'b1);
    repeat (3) tick();
    check("post_rst", data_out, 8'h81);
    consume();
`ifdef UART_RX_PARITY_EN
    f0 = perr_cnt;
    send_bad_parity(8'h81);
    repeat (5) tick();
    check("perr_pulse", perr_cnt - f0, 1);
    check("perr_valid", data_out_valid, 1'b0);
    check("perr_ovr", overrun, 1'b0);
`endif

    // Randomized frames and idle gaps, consumer always ready
    ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      rb  = 8'($urandom);
      gap = int'($urandom_range(0, 15));
      send_frame(rb, 1'b1);
      repeat (gap) tick();
    end
    repeat (10) tick();
    ready = 1'b0;

    // Scoreboard: every accepted byte, in order
    check("q_len", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("q[%0d]", i), got_q[i], exp_q[i]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
